// File: rtl/w5300_host_bus_pkg.sv
// w5300_host_bus_pkg
//   Shared definitions for the W5300 16-bit direct parallel host-bus engine:
//   request WR/RD encoding (addr bit 10), the bus state enum, and default
//   strobe timing used when the top is instantiated without overrides.
package w5300_host_bus_pkg;

    // Request encoding, shared with the common-register and socket FSMs
    localparam logic W5300_WR     = 1'b1;
    localparam logic W5300_RD     = 1'b0;
    localparam int   W5300_RW_BIT = 10;

    // Default bus timing, in clk cycles
    localparam int W5300_DEF_SETUP_CYCLES  = 1;
    localparam int W5300_DEF_STROBE_CYCLES = 4;
    localparam int W5300_DEF_HOLD_CYCLES   = 1;

    typedef enum logic [2:0] {
        ST_CHIP_RESET = 3'd0,
        ST_PLL_WAIT   = 3'd1,
        ST_IDLE       = 3'd2,
        ST_SETUP      = 3'd3,
        ST_STROBE     = 3'd4,
        ST_HOLD       = 3'd5
    } bus_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/w5300_host_bus_chip_reset_seq.sv
// w5300_chip_reset_seq
//   Drives the W5300 RESET pin low for RST_PULSE_CYCLES after rst releases,
//   then waits PLL_LOCK_CYCLES for the chip PLL to lock.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   chip_rst_n_o     W5300 RESET pin (registered)
//   done_o           high from the last PLL-wait cycle onward; the main FSM
//                    moves to Idle on the edge that ends that cycle
module w5300_chip_reset_seq
    import w5300_host_bus_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = 250,
    parameter int PLL_LOCK_CYCLES  = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic chip_rst_n_o,
    output logic done_o
);

    localparam int CW = $clog2(max2(RST_PULSE_CYCLES, PLL_LOCK_CYCLES) + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pll_q, pll_d;   // 0 = pulse phase, 1 = PLL wait phase

    always_comb begin
        cnt_d = cnt_q;
        pll_d = pll_q;
        if (!pll_q) begin
            if (cnt_q == '0) begin
                pll_d = 1'b1;
                cnt_d = CW'(PLL_LOCK_CYCLES - 1);
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (cnt_q != '0) begin
            // Counter parks at zero once the wait has elapsed
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= CW'(RST_PULSE_CYCLES - 1);
            pll_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pll_q <= pll_d;
        end
    end

    assign chip_rst_n_o = pll_q;
    assign done_o       = pll_q && (cnt_q == '0);

endmodule

// File: rtl/w5300_host_bus.sv
// w5300_host_bus
//   Physical host-bus engine for the W5300 16-bit direct parallel interface.
//   Sequences chip reset and PLL lock, then runs one register access per
//   request: Idle (latch) -> Setup -> Strobe -> Hold, with op_state pulsing
//   on the last Hold cycle.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   enable, addr, wr_data       request (addr[10]=1 write, addr[9:0] register)
//   rd_data, op_state, ready    read result, completion pulse, init done
//   w5300_rst_n/cs_n/rd_n/wr_n  chip control pins (registered)
//   w5300_addr, w5300_data_o,
//   w5300_data_oe, w5300_data_i address pins and split tristate data bus
//   w5300_int_n, irq            chip interrupt in, interrupt level out
// Build option: define W5300_INT_SYNC_EN to synchronise w5300_int_n into irq;
//   otherwise irq is tied low.
module w5300_host_bus
    import w5300_host_bus_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = 250,
    parameter int PLL_LOCK_CYCLES  = 500000,
    parameter int SETUP_CYCLES     = W5300_DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES    = W5300_DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES      = W5300_DEF_HOLD_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [10:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        op_state,
    output logic        ready,
    output logic        w5300_rst_n,
    output logic        w5300_cs_n,
    output logic        w5300_rd_n,
    output logic        w5300_wr_n,
    output logic [9:0]  w5300_addr,
    output logic [15:0] w5300_data_o,
    output logic        w5300_data_oe,
    input  logic [15:0] w5300_data_i,
    input  logic        w5300_int_n,
    output logic        irq
);

    if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1 ||
        RST_PULSE_CYCLES < 1 || PLL_LOCK_CYCLES < 1) begin : g_bad_timing
        $error("w5300_host_bus: all cycle parameters must be >= 1");
    end

    localparam int BW = $clog2(max2(max2(SETUP_CYCLES, STROBE_CYCLES), HOLD_CYCLES) + 1);

    logic seq_rst_n, seq_done;

    w5300_chip_reset_seq #(
        .RST_PULSE_CYCLES (RST_PULSE_CYCLES),
        .PLL_LOCK_CYCLES  (PLL_LOCK_CYCLES)
    ) u_chip_reset_seq (
        .clk_i        (clk),
        .rst_i        (rst),
        .chip_rst_n_o (seq_rst_n),
        .done_o       (seq_done)
    );

    bus_state_e    state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          lat_wr_q, lat_wr_d;
    logic [9:0]    lat_addr_q, lat_addr_d;
    logic [15:0]   lat_data_q, lat_data_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic          oe_q, oe_d, op_q, op_d, ready_q, ready_d;
    logic          busy_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_wr_d   = lat_wr_q;
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            ST_CHIP_RESET, ST_PLL_WAIT: begin
                // Mirrors the sequencer; done is early by one cycle so that
                // Idle and ready arrive exactly PLL_LOCK_CYCLES after release
                if (seq_done)       state_d = ST_IDLE;
                else if (seq_rst_n) state_d = ST_PLL_WAIT;
            end
            ST_IDLE: begin
                if (enable) begin
                    lat_wr_d   = (addr[W5300_RW_BIT] == W5300_WR);
                    lat_addr_d = addr[9:0];
                    lat_data_d = wr_data;
                    cnt_d      = BW'(SETUP_CYCLES - 1);
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = BW'(STROBE_CYCLES - 1);
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    // Sample the pins on the edge that ends the strobe
                    if (!lat_wr_q) rd_data_d = w5300_data_i;
                    cnt_d   = BW'(HOLD_CYCLES - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_CHIP_RESET;
        endcase

        // Pin values are registered from the next state so the chip sees
        // clean, glitch-free strobes
        busy_d  = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_n_d  = !busy_d;
        rd_n_d  = !((state_d == ST_STROBE) && !lat_wr_d);
        wr_n_d  = !((state_d == ST_STROBE) &&  lat_wr_d);
        oe_d    = busy_d && lat_wr_d;
        op_d    = (state_d == ST_HOLD) && (cnt_d == '0);
        ready_d = ready_q || (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CHIP_RESET;
            cnt_q      <= '0;
            lat_wr_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            rd_data_q  <= '0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            oe_q       <= 1'b0;
            op_q       <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_wr_q   <= lat_wr_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
            rd_data_q  <= rd_data_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            oe_q       <= oe_d;
            op_q       <= op_d;
            ready_q    <= ready_d;
        end
    end

    assign rd_data       = rd_data_q;
    assign op_state      = op_q;
    assign ready         = ready_q;
    assign w5300_rst_n   = seq_rst_n;
    assign w5300_cs_n    = cs_n_q;
    assign w5300_rd_n    = rd_n_q;
    assign w5300_wr_n    = wr_n_q;
    assign w5300_addr    = lat_addr_q;
    assign w5300_data_o  = lat_data_q;
    assign w5300_data_oe = oe_q;

`ifdef W5300_INT_SYNC_EN
    logic [1:0] int_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) int_sync_q <= 2'b11;
        else     int_sync_q <= {int_sync_q[0], w5300_int_n};
    end

    assign irq = ready_q & ~int_sync_q[1];
`else
    logic unused_int_n;
    assign unused_int_n = w5300_int_n;
    assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_w5300_host_bus.sv
module tb_w5300_host_bus;

    localparam int RSTC = 10;
    localparam int PLLC = 20;
    localparam int S    = 1;
    localparam int T    = 4;
    localparam int H    = 1;
    localparam int ACC  = S + T + H;   // cycles from latch edge to op_state cycle

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [10:0] addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        op_state, ready, w5300_rst_n, w5300_cs_n, w5300_rd_n, w5300_wr_n;
    logic [9:0]  w5300_addr;
    logic [15:0] w5300_data_o, w5300_data_i;
    logic        w5300_data_oe;
    logic        w5300_int_n = 1'b1;
    logic        irq;

    always #5 clk = ~clk;

    w5300_host_bus #(
        .RST_PULSE_CYCLES (RSTC),
        .PLL_LOCK_CYCLES  (PLLC),
        .SETUP_CYCLES     (S),
        .STROBE_CYCLES    (T),
        .HOLD_CYCLES      (H)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .op_state      (op_state),
        .ready         (ready),
        .w5300_rst_n   (w5300_rst_n),
        .w5300_cs_n    (w5300_cs_n),
        .w5300_rd_n    (w5300_rd_n),
        .w5300_wr_n    (w5300_wr_n),
        .w5300_addr    (w5300_addr),
        .w5300_data_o  (w5300_data_o),
        .w5300_data_oe (w5300_data_oe),
        .w5300_data_i  (w5300_data_i),
        .w5300_int_n   (w5300_int_n),
        .irq           (irq)
    );

    // Chip-side register file driven purely by the pins
    logic [15:0] bus_mem [1024];
    assign w5300_data_i = (!w5300_rd_n && !w5300_cs_n) ? bus_mem[w5300_addr] : 16'hFFFF;
    always @(posedge w5300_wr_n) if (!w5300_cs_n) bus_mem[w5300_addr] <= w5300_data_o;

    // Request-level reference: what each register should hold, and rd_data
    logic [15:0] ref_mem [1024];
    logic [15:0] exp_rd;

    int nvec = 0;
    int nerr = 0;

    // Measurements of one access
    int m_cs, m_wr, m_rd, m_oe, m_fwr, m_frd, m_op, m_opn, m_pin;
    logic [15:0] m_rdat;
    // Measurements of one reset sequence
    int r_low, r_pll, r_cs, r_irq;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic run_access(input logic wr, input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        enable = 1'b1; addr = {wr, a}; wr_data = d;
        @(posedge clk);
        #1;
        // Request bus scrambled and enable dropped right after the latch
        enable = 1'b0; addr = 11'($urandom); wr_data = 16'($urandom);
        m_cs = 0; m_wr = 0; m_rd = 0; m_oe = 0; m_fwr = -1; m_frd = -1;
        m_op = -1; m_opn = 0; m_pin = 0; m_rdat = 16'hxxxx;
        for (int c = 1; c <= ACC + 6; c++) begin
            @(negedge clk);
            if (!w5300_cs_n) begin
                m_cs++;
                if (w5300_addr !== a) m_pin++;
                if (wr && (w5300_data_o !== d || w5300_data_oe !== 1'b1)) m_pin++;
            end
            if (!w5300_wr_n) begin m_wr++; if (m_fwr < 0) m_fwr = c; end
            if (!w5300_rd_n) begin m_rd++; if (m_frd < 0) m_frd = c; end
            if (w5300_data_oe) m_oe++;
            if (op_state) begin m_opn++; if (m_op < 0) begin m_op = c; m_rdat = rd_data; end end
        end
    endtask

    task automatic release_and_measure();
        @(posedge clk);
        #1 rst = 1'b0;
        enable = 1'b1; addr = 11'h7FF;   // must be ignored until ready
        w5300_int_n = 1'b0;              // irq must stay 0 until ready
        r_low = 0; r_pll = 0; r_cs = 0; r_irq = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!w5300_cs_n) r_cs++;
            if (irq) r_irq++;
            if (!w5300_rst_n) r_low++;
            else if (!ready) r_pll++;
            else break;
        end
        enable = 1'b0;
        w5300_int_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nvec++;
        if ({w5300_rst_n, w5300_cs_n, w5300_rd_n, w5300_wr_n, w5300_data_oe, w5300_addr,
             w5300_data_o, rd_data, op_state, ready, irq}
            !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL reset_values: rst_n=%b cs=%b rd=%b wr=%b oe=%b a=%h do=%h rd=%h op=%b rdy=%b irq=%b",
                     w5300_rst_n, w5300_cs_n, w5300_rd_n, w5300_wr_n, w5300_data_oe, w5300_addr,
                     w5300_data_o, rd_data, op_state, ready, irq);
        end
        release_and_measure();
        nvec++; if (r_low !== RSTC) begin nerr++; $display("FAIL rst_pulse: got %0d want %0d", r_low, RSTC); end
        nvec++; if (r_pll !== PLLC) begin nerr++; $display("FAIL pll_wait: got %0d want %0d", r_pll, PLLC); end
        nvec++; if (r_cs !== 0) begin nerr++; $display("FAIL cs_during_init: got %0d want 0", r_cs); end
        nvec++; if (r_irq !== 0) begin nerr++; $display("FAIL irq_during_init: got %0d want 0", r_irq); end
        exp_rd = 16'h0000;
    endtask

    task automatic test_write();
        run_access(1'b1, 10'h000, 16'h0001);
        ref_mem[0] = 16'h0001;
        nvec++; if (m_cs !== ACC) begin nerr++; $display("FAIL wr_cs_low: got %0d want %0d", m_cs, ACC); end
        nvec++; if (m_wr !== T) begin nerr++; $display("FAIL wr_strobe: got %0d want %0d", m_wr, T); end
        nvec++; if (m_fwr !== S + 1) begin nerr++; $display("FAIL wr_strobe_start: got %0d want %0d", m_fwr, S + 1); end
        nvec++; if (m_oe !== ACC) begin nerr++; $display("FAIL wr_oe: got %0d want %0d", m_oe, ACC); end
        nvec++; if (m_pin !== 0) begin nerr++; $display("FAIL wr_pins: got %0d bad samples want 0", m_pin); end
        nvec++; if (m_op !== ACC || m_opn !== 1) begin nerr++; $display("FAIL wr_op_state: at %0d count %0d want at %0d count 1", m_op, m_opn, ACC); end
        nvec++; if (m_rd !== 0) begin nerr++; $display("FAIL wr_no_rd: got %0d want 0", m_rd); end
    endtask

    task automatic test_read();
        bus_mem[10'h208] = 16'h0017;
        ref_mem[10'h208] = 16'h0017;
        run_access(1'b0, 10'h208, 16'hBEEF);
        exp_rd = 16'h0017;
        nvec++; if (m_rd !== T || m_frd !== S + 1) begin nerr++; $display("FAIL rd_strobe: got %0d from %0d want %0d from %0d", m_rd, m_frd, T, S + 1); end
        nvec++; if (m_oe !== 0) begin nerr++; $display("FAIL rd_oe: got %0d want 0", m_oe); end
        nvec++; if (m_rdat !== exp_rd) begin nerr++; $display("FAIL rd_data: got %h want %h", m_rdat, exp_rd); end
        run_access(1'b1, 10'h001, 16'hA5A5);
        ref_mem[1] = 16'hA5A5;
        nvec++; if (rd_data !== exp_rd) begin nerr++; $display("FAIL rd_hold_after_wr: got %h want %h", rd_data, exp_rd); end
    endtask

    task automatic test_random();
        logic wr; logic [9:0] a; logic [15:0] d;
        for (int k = 0; k < 24; k++) begin
            a  = 10'h100 + 10'($urandom_range(0, 7));
            wr = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk); addr = 11'($urandom); wr_data = 16'($urandom);
            end
            run_access(wr, a, d);
            if (wr) ref_mem[a] = d;
            else    exp_rd = ref_mem[a];
            nvec++; if (m_op !== ACC || m_opn !== 1) begin nerr++; $display("FAIL rnd%0d_op: at %0d count %0d", k, m_op, m_opn); end
            nvec++; if (m_cs !== ACC || m_pin !== 0) begin nerr++; $display("FAIL rnd%0d_bus: cs %0d badpins %0d want %0d/0", k, m_cs, m_pin, ACC); end
            nvec++; if ((wr ? m_wr : m_rd) !== T || (wr ? m_rd : m_wr) !== 0) begin nerr++; $display("FAIL rnd%0d_strobe: wr %0d rd %0d want %0d", k, m_wr, m_rd, T); end
            nvec++; if (m_oe !== (wr ? ACC : 0)) begin nerr++; $display("FAIL rnd%0d_oe: got %0d", k, m_oe); end
            nvec++; if (m_rdat !== exp_rd) begin nerr++; $display("FAIL rnd%0d_rd_data: got %h want %h", k, m_rdat, exp_rd); end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  qa [11];
        logic [15:0] qd [11];
        int idx = 0, pulses = 0, last = -1, t = 0, gap_err = 0, pin_err = 0, extra = 0;
        for (int i = 0; i < 11; i++) begin
            qa[i] = 10'h180 + 10'(i * 3);
            qd[i] = 16'($urandom);
            ref_mem[qa[i]] = qd[i];
        end
        @(negedge clk);
        enable = 1'b1; addr = {1'b1, qa[0]}; wr_data = qd[0];
        while (pulses < 11 && t < 300) begin
            @(negedge clk);
            t++;
            if (!w5300_cs_n && (w5300_addr !== qa[idx] || w5300_data_o !== qd[idx])) pin_err++;
            if (op_state) begin
                if (last >= 0 && t - last != ACC + 1) gap_err++;
                last = t; pulses++; idx++;
                // Requester advances on op_state
                if (idx < 11) begin addr = {1'b1, qa[idx]}; wr_data = qd[idx]; end
                else enable = 1'b0;
            end
        end
        repeat (12) begin @(negedge clk); if (op_state || !w5300_cs_n) extra++; end
        nvec++; if (pulses !== 11) begin nerr++; $display("FAIL b2b_pulses: got %0d want 11", pulses); end
        nvec++; if (gap_err !== 0) begin nerr++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_err); end
        nvec++; if (pin_err !== 0) begin nerr++; $display("FAIL b2b_pins: got %0d bad samples want 0", pin_err); end
        nvec++; if (extra !== 0) begin nerr++; $display("FAIL b2b_stop: got %0d activity cycles want 0", extra); end
        run_access(1'b0, qa[10], 16'h0);
        exp_rd = ref_mem[qa[10]];
        nvec++; if (m_rdat !== exp_rd) begin nerr++; $display("FAIL b2b_readback: got %h want %h", m_rdat, exp_rd); end
    endtask

    task automatic test_reset_mid();
        int opn = 0;
        @(negedge clk);
        enable = 1'b1; addr = {1'b0, 10'h208}; wr_data = 16'h0;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (S + 2) @(negedge clk);
        nvec++; if (w5300_rd_n !== 1'b0) begin nerr++; $display("FAIL mid_in_strobe: rd_n=%b want 0", w5300_rd_n); end
        rst = 1'b1;
        #1;
        exp_rd = 16'h0000;
        nvec++;
        if ({w5300_cs_n, w5300_rd_n, w5300_wr_n, w5300_data_oe, w5300_rst_n, ready, rd_data}
            !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_rd}) begin
            nerr++;
            $display("FAIL mid_reset_pins: cs=%b rd=%b wr=%b oe=%b rst_n=%b rdy=%b rd_data=%h",
                     w5300_cs_n, w5300_rd_n, w5300_wr_n, w5300_data_oe, w5300_rst_n, ready, rd_data);
        end
        repeat (4) begin @(negedge clk); if (op_state) opn++; end
        release_and_measure();
        nvec++; if (opn !== 0) begin nerr++; $display("FAIL mid_no_op: got %0d want 0", opn); end
        nvec++; if (r_low !== RSTC || r_pll !== PLLC) begin nerr++; $display("FAIL mid_restart: low %0d pll %0d want %0d %0d", r_low, r_pll, RSTC, PLLC); end
        run_access(1'b1, 10'h002, 16'h1234);
        ref_mem[2] = 16'h1234;
        nvec++; if (m_op !== ACC || m_rdat !== exp_rd) begin nerr++; $display("FAIL mid_after: op at %0d rd %h want %0d %h", m_op, m_rdat, ACC, exp_rd); end
    endtask

    task automatic test_irq();
        logic [2:0] seen;
        @(negedge clk);
        w5300_int_n = 1'b0;
        for (int c = 0; c < 3; c++) begin @(negedge clk); seen[c] = irq; end
        w5300_int_n = 1'b1;
        repeat (3) @(negedge clk);
`ifdef W5300_INT_SYNC_EN
        nvec++; if (seen !== 3'b110) begin nerr++; $display("FAIL irq_latency: got %b want 110", seen); end
`else
        nvec++; if (seen !== 3'b000) begin nerr++; $display("FAIL irq_tied: got %b want 000", seen); end
`endif
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_release: got %b want 0", irq); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bus_mem[i] = 16'(i * 37 + 5);
            ref_mem[i] = 16'(i * 37 + 5);
        end
        exp_rd = 16'h0000;
        test_reset();
        test_write();
        test_read();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_irq();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
